// File: rtl/mod997_chunk_sequencer_pkg.sv
// Shared constants, FSM state type and modular-add helper for the mod-997 chunk reducer.
package mod997_pkg;
  localparam int N_BITS  = 300;
  localparam int CHUNK_W = 6;
  localparam int MOD     = 997;
  localparam int RES_W   = 10;
  localparam int NCHUNK  = (N_BITS + CHUNK_W - 1) / CHUNK_W;
  localparam int IDX_W   = $clog2(NCHUNK);
  localparam int PAD_W   = NCHUNK * CHUNK_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Both operands are below MOD, so a single conditional subtract normalises the sum.
  function automatic logic [RES_W-1:0] mod_add(input logic [RES_W-1:0] a,
                                                input logic [RES_W-1:0] b);
    logic [RES_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (RES_W+1)'(MOD)) begin
      sum = sum - (RES_W+1)'(MOD);
    end
    return sum[RES_W-1:0];
  endfunction
endpackage

// File: rtl/mod997_chunk_sequencer_if.sv
// Operand, LUT-bank and result signals of the chunk sequencer, grouped with producer/block views.
interface mod997_chunk_sequencer_if;
  import mod997_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [N_BITS-1:0]  in_data;
  logic               flush;
  logic [IDX_W-1:0]   lut_idx;
  logic [CHUNK_W-1:0] lut_x;
  logic [RES_W-1:0]   lut_z;
  logic               out_valid;
  logic               out_ready;
  logic [RES_W-1:0]   out_res;
  logic               busy;

  modport master (
    output in_valid, in_data, flush, lut_z, out_ready,
    input  in_ready, lut_idx, lut_x, out_valid, out_res, busy
  );

  modport slave (
    input  in_valid, in_data, flush, lut_z, out_ready,
    output in_ready, lut_idx, lut_x, out_valid, out_res, busy
  );
endinterface

// File: rtl/mod997_acc_add.sv
// Combinational modular adder: for a, b < MOD returns (a + b) mod MOD.
module mod997_acc_add
  import mod997_pkg::*;
(
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  output logic [RES_W-1:0] y
);
  assign y = mod_add(a, b);
endmodule

// File: rtl/mod997_chunk_sequencer.sv
// Sequential mod-997 reducer: walks the operand one 6-bit chunk per cycle through an external
// residue LUT bank and accumulates the returned residues modulo 997.
module mod997_chunk_sequencer
  import mod997_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  mod997_chunk_sequencer_if.slave  bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [PAD_W-1:0] operand_reg;
  logic [RES_W-1:0] acc_reg;
  logic [RES_W-1:0] acc_next;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;

  mod997_acc_add u_acc_add (
    .a (acc_reg),
    .b (bus.lut_z),
    .y (acc_next)
  );

  // The operand shifts down one chunk per step, so the current chunk always sits in the low bits.
  // The final step leaves it unshifted so lut_x keeps showing the last chunk afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      operand_reg   <= '0;
      acc_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else if (bus.flush) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            operand_reg  <= PAD_W'(bus.in_data);
            idx_reg      <= '0;
            acc_reg      <= '0;
            state_reg    <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          if (idx_reg == LAST_IDX) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end else begin
            idx_reg     <= idx_reg + IDX_W'(1);
            operand_reg <= operand_reg >> CHUNK_W;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.lut_idx   = idx_reg;
  assign bus.lut_x     = operand_reg[CHUNK_W-1:0];
  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_res   = acc_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_mod997_chunk_sequencer.sv
// Randomised self-checking bench for mod997_chunk_sequencer against a bitwise big-integer model.
module tb_mod997_chunk_sequencer;
  import mod997_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   pow_tab [64];

  mod997_chunk_sequencer_if bus ();

  mod997_chunk_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: Horner evaluation bit by bit from the MSB, independent of chunking.
  function automatic int golden(input logic [N_BITS-1:0] v);
    int r;
    r = 0;
    for (int i = N_BITS - 1; i >= 0; i--) r = (r * 2 + int'(v[i])) % MOD;
    return r;
  endfunction

  // LUT bank model: chunk value times (2^(6k) mod 997).
  always_comb begin
    bus.lut_z = RES_W'((int'(bus.lut_x) * pow_tab[int'(bus.lut_idx)]) % MOD);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N_BITS-1:0] rand_op();
    logic [319:0] w;
    int sel;
    for (int j = 0; j < 10; j++) w[j*32 +: 32] = $urandom;
    sel = $urandom_range(0, 3);
    if (sel == 0) w = w & 320'hFFFF;
    else if (sel == 1) w = w >> $urandom_range(0, 299);
    return w[N_BITS-1:0];
  endfunction

  // Offers one operand, waits for the result, optionally holds off the consumer, then drains it.
  task automatic do_op(input logic [N_BITS-1:0] op, input int hold, input bit chk_lat);
    int lat;
    int exp;
    int res_first;
    exp = golden(op);
    bus.in_data  = op;
    bus.in_valid = 1'b1;
    lat = 0;
    while (!bus.in_ready && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    check("in_ready_idle", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    check("busy_after_accept", int'(bus.busy), 1);
    // Offers while busy must be ignored.
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.in_data  = rand_op();
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check("out_valid_seen", int'(bus.out_valid), 1);
    if (chk_lat) check("latency", lat + 1, NCHUNK + 1);
    check("out_res", int'(bus.out_res), exp);
    res_first = int'(bus.out_res);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_res", int'(bus.out_res), res_first);
      check("hold_in_ready", int'(bus.in_ready), 0);
      check("hold_valid", int'(bus.out_valid), 1);
      check("hold_lut_idx", int'(bus.lut_idx), NCHUNK - 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("drain_valid", int'(bus.out_valid), 0);
    check("drain_in_ready", int'(bus.in_ready), 1);
  endtask

  initial begin
    logic [N_BITS-1:0] v;
    int lat;
    int seen;

    for (int k = 0; k < 64; k++) begin
      v = '0;
      if (k < NCHUNK) begin
        v[k*CHUNK_W] = 1'b1;
        pow_tab[k] = golden(v);
      end else begin
        pow_tab[k] = 0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_out_res", int'(bus.out_res), 0);
    check("rst_lut_idx", int'(bus.lut_idx), 0);
    check("rst_lut_x", int'(bus.lut_x), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed values, including chunk boundaries and the conditional subtract.
    do_op('0, 0, 1);
    v = N_BITS'(996);  do_op(v, 0, 1);
    v = N_BITS'(997);  do_op(v, 0, 1);
    v = N_BITS'(1994); do_op(v, 0, 1);
    v = N_BITS'(64);   do_op(v, 0, 1);
    v = '0; v[294] = 1'b1; do_op(v, 0, 1);
    v = '1; do_op(v, 0, 1);

    // Back-pressure: 20 stalled cycles in DONE.
    do_op(rand_op(), 20, 1);

    // Flush in the same cycle as an offer: flush wins.
    bus.in_valid = 1'b1;
    bus.in_data  = rand_op();
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_vs_accept_busy", int'(bus.busy), 0);
    check("flush_vs_accept_ready", int'(bus.in_ready), 1);

    // Flush while RUN is at chunk 25.
    bus.in_valid = 1'b1;
    bus.in_data  = rand_op();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.lut_idx != IDX_W'(25) && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("flush_reach_idx25", int'(bus.lut_idx), 25);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy", int'(bus.busy), 0);
    check("flush_in_ready", int'(bus.in_ready), 1);
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    check("flush_no_result", seen, 0);
    v = N_BITS'(997); do_op(v, 0, 1);

    // Asynchronous reset pulse in the middle of RUN.
    bus.in_valid = 1'b1;
    bus.in_data  = rand_op();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", int'(bus.in_ready), 1);
    check("arst_out_valid", int'(bus.out_valid), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_out_res", int'(bus.out_res), 0);
    check("arst_lut_idx", int'(bus.lut_idx), 0);
    check("arst_lut_x", int'(bus.lut_x), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Random back-to-back stream.
    for (int n = 0; n < 1000; n++) begin
      do_op(rand_op(), $urandom_range(0, 3), (n % 50) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
